fact_job_scheduler: RTL and testbench

Job scheduler sitting between a requester and the memory-mapped factorial accelerator. It queues factorial jobs (4-bit operand n) in a job FIFO and drives the accelerator's register bus to run them one at a time: load n, pulse Go, poll status, read result. Results, each with an error flag, go into a result FIFO in issue order. This frees the MIPS core from busy-polling the accelerator.

---
 rtl/fact_job_scheduler_pkg.sv | 10 +
 rtl/fact_job_scheduler_if.sv | 24 ++
 rtl/fact_job_scheduler_fifo.sv | 38 +++
 rtl/fact_job_scheduler.sv | 106 ++++++++++
 tb/tb_fact_job_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fact_job_scheduler_pkg.sv
// fact_sched_pkg: scheduler FSM states and the accelerator register map
package fact_sched_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_N, GO, WAIT, READ} state_t;
  localparam logic [1:0] ACC_DATA = 2'b00;
  localparam logic [1:0] ACC_CTRL = 2'b01;
  localparam logic [1:0] ACC_STAT = 2'b10;
  localparam logic [1:0] ACC_RES  = 2'b11;
  localparam int DONE_BIT = 0;
  localparam int ERR_BIT  = 1;
endpackage

// File: rtl/fact_job_scheduler_if.sv
// fact_job_scheduler_if: requester job/result signals and the accelerator register bus
interface fact_job_scheduler_if;
  logic        job_push;
  logic [3:0]  job_n;
  logic        job_full;
  logic        job_drop;
  logic        res_pop;
  logic [31:0] res_data;
  logic        res_err;
  logic        res_empty;
  logic        busy;
  logic [1:0]  acc_addr;
  logic        acc_we;
  logic [3:0]  acc_wdata;
  logic [31:0] acc_rdata;
  modport slave (
    input  job_push, job_n, res_pop, acc_rdata,
    output job_full, job_drop, res_data, res_err, res_empty, busy, acc_addr, acc_we, acc_wdata
  );
  modport master (
    output job_push, job_n, res_pop, acc_rdata,
    input  job_full, job_drop, res_data, res_err, res_empty, busy, acc_addr, acc_we, acc_wdata
  );
endinterface

// File: rtl/fact_job_scheduler_fifo.sv
// sync_fifo: first-word-fall-through FIFO, full/empty from pre-edge pointers
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    dout = empty ? '0 : mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fact_job_scheduler.sv
// fact_job_scheduler: queues factorial jobs and runs them one at a time on the accelerator bus
module fact_job_scheduler
  import fact_sched_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  fact_job_scheduler_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic [3:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q, err_d, drop_q, drop_d;
  logic job_empty, job_full, job_pop, res_full, res_push, res_empty;
  logic [3:0] job_dout;
  logic [32:0] res_din, res_dout;
  logic [1:0] acc_addr;
  logic acc_we;
  logic [3:0] acc_wdata;
  sync_fifo #(.WIDTH(4), .DEPTH(DEPTH)) u_job (
    .clk(clk), .reset(reset), .push(bus.job_push), .pop(job_pop), .din(bus.job_n),
    .dout(job_dout), .full(job_full), .empty(job_empty)
  );
  sync_fifo #(.WIDTH(33), .DEPTH(DEPTH)) u_res (
    .clk(clk), .reset(reset), .push(res_push), .pop(bus.res_pop), .din(res_din),
    .dout(res_dout), .full(res_full), .empty(res_empty)
  );
  assign bus.job_full  = job_full;
  assign bus.job_drop  = drop_q;
  assign bus.res_empty = res_empty;
  assign bus.res_err   = res_dout[32];
  assign bus.res_data  = res_dout[31:0];
  assign bus.busy      = state_q != IDLE;
  assign bus.acc_addr  = acc_addr;
  assign bus.acc_we    = acc_we;
  assign bus.acc_wdata = acc_wdata;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    cnt_d = cnt_q;
    err_d = err_q;
    drop_d = bus.job_push && job_full;
    job_pop = 1'b0;
    res_push = 1'b0;
    res_din = '0;
    acc_addr = ACC_STAT;
    acc_we = 1'b0;
    acc_wdata = '0;
    case (state_q)
      IDLE: if (!job_empty && !res_full) begin
        job_pop = 1'b1;
        n_d = job_dout;
        state_d = LOAD_N;
      end
      LOAD_N: begin
        acc_addr = ACC_DATA;
        acc_we = 1'b1;
        acc_wdata = n_q;
        state_d = GO;
      end
      GO: begin
        acc_addr = ACC_CTRL;
        acc_we = 1'b1;
        acc_wdata = 4'b0001;
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (bus.acc_rdata[DONE_BIT] || bus.acc_rdata[ERR_BIT]) begin
        err_d = bus.acc_rdata[ERR_BIT];
        state_d = READ;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        res_push = 1'b1;
        res_din = {1'b1, 32'd0};
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      READ: begin
        acc_addr = ACC_RES;
        res_push = 1'b1;
        res_din = {err_q, bus.acc_rdata};
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_fact_job_scheduler.sv
// tb_fact_job_scheduler: randomized scoreboard bench with a behavioural accelerator stub
module tb_fact_job_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fact_job_scheduler_if bus();
  fact_job_scheduler #(.DEPTH(4), .TIMEOUT(8)) dut (.clk(clk), .reset(rst), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  int polls_q[$];
  int go_cnt = 0;
  int cur_polls = 0;
  bit polling = 0;
  bit pop_en = 1, pop_one = 0, rand_pop = 0, never = 0, inject = 0, rand_lat = 0;
  int lat = 3;
  logic [3:0] a_n;
  logic a_done, a_err, a_run;
  logic [31:0] a_res;
  int a_cnt;
  function automatic logic [31:0] fact(input logic [3:0] n);
    logic [31:0] r = 32'd1;
    for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
    return r;
  endfunction
  function automatic logic [32:0] model(input logic [3:0] n);
    return never ? {1'b1, 32'd0} : {inject && n == 4'd15, fact(n)};
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      a_n <= '0; a_done <= 1'b0; a_err <= 1'b0; a_run <= 1'b0; a_res <= '0; a_cnt <= 0;
    end else begin
      if (bus.acc_we && bus.acc_addr == 2'b00) a_n <= bus.acc_wdata;
      if (bus.acc_we && bus.acc_addr == 2'b01 && bus.acc_wdata[0]) begin
        a_done <= 1'b0; a_err <= 1'b0; a_run <= 1'b1; a_res <= fact(a_n);
        a_cnt <= rand_lat ? int'($urandom_range(1, 5)) : lat;
      end else if (a_run && !never) begin
        if (a_cnt <= 1) begin
          a_run <= 1'b0;
          if (inject && a_n == 4'd15) a_err <= 1'b1;
          else a_done <= 1'b1;
        end else a_cnt <= a_cnt - 1;
      end
    end
  end
  always_comb begin
    case (bus.acc_addr)
      2'b00: bus.acc_rdata = {28'd0, a_n};
      2'b10: bus.acc_rdata = {30'd0, a_err, a_done};
      2'b11: bus.acc_rdata = a_res;
      default: bus.acc_rdata = '0;
    endcase
  end
  initial forever begin
    @(negedge clk);
    if (rst) polling = 0;
    else if (bus.acc_we && bus.acc_addr == 2'b01) begin
      go_cnt++;
      chk("go_wdata", 32'(bus.acc_wdata), 32'd1);
      polling = 1;
      cur_polls = 0;
    end else if (polling && bus.busy && bus.acc_addr == 2'b10 && !bus.acc_we) cur_polls++;
    else if (polling) begin
      polls_q.push_back(cur_polls);
      polling = 0;
    end
  end
  initial begin
    logic [32:0] e;
    bus.res_pop = 1'b0;
    forever begin
      @(negedge clk);
      bus.res_pop = 1'b0;
      if (!rst && !bus.res_empty && ((pop_en && (!rand_pop || $urandom_range(0, 2) != 0)) || pop_one)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: got %0h expected none", bus.res_data);
        end else begin
          e = exp_q.pop_front();
          chk("res_err", 32'(bus.res_err), 32'(e[32]));
          chk("res_data", bus.res_data, e[31:0]);
        end
        bus.res_pop = 1'b1;
        pop_one = 0;
      end
    end
  end
  task automatic push_job(input logic [3:0] n);
    int t = 0;
    while (bus.job_full && t < 200) begin @(negedge clk); t++; end
    if (bus.job_full) begin
      checks++; errors++;
      $display("FAIL push_wait: job_full got 1 expected 0");
    end else begin
      bus.job_push = 1'b1;
      bus.job_n = n;
      exp_q.push_back(model(n));
      @(negedge clk);
      bus.job_push = 1'b0;
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.busy || !bus.res_empty) && t < 1000) begin @(negedge clk); t++; end
    checks++;
    if (t >= 1000) begin
      errors++;
      $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end
  initial begin
    int g0, t;
    bus.job_push = 1'b0;
    bus.job_n = '0;
    repeat (3) @(negedge clk);
    chk("rst_job_full", 32'(bus.job_full), 0);
    chk("rst_job_drop", 32'(bus.job_drop), 0);
    chk("rst_res_empty", 32'(bus.res_empty), 1);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_res_err", 32'(bus.res_err), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_acc_addr", 32'(bus.acc_addr), 2);
    chk("rst_acc_we", 32'(bus.acc_we), 0);
    chk("rst_acc_wdata", 32'(bus.acc_wdata), 0);
    rst = 1'b0;
    @(negedge clk);
    lat = 3;
    push_job(4'd5);
    chk("t1_busy_before", 32'(bus.busy), 0);
    @(negedge clk);
    chk("t1_load_busy", 32'(bus.busy), 1);
    chk("t1_load_addr", 32'(bus.acc_addr), 0);
    chk("t1_load_we", 32'(bus.acc_we), 1);
    chk("t1_load_wdata", 32'(bus.acc_wdata), 5);
    @(negedge clk);
    chk("t1_go_addr", 32'(bus.acc_addr), 1);
    chk("t1_go_we", 32'(bus.acc_we), 1);
    drain();
    chk("t1_poll_entries", polls_q.size(), 1);
    if (polls_q.size() > 0) chk("t1_polls", polls_q.pop_front(), lat + 1);
    chk("t1_busy_after", 32'(bus.busy), 0);
    g0 = go_cnt;
    push_job(4'd3); push_job(4'd4); push_job(4'd0);
    drain();
    chk("b2b_go_writes", go_cnt - g0, 3);
    lat = 5;
    for (int i = 0; i < 6; i++) begin
      bus.job_push = 1'b1;
      bus.job_n = 4'(i + 1);
      if (i < 5) exp_q.push_back(model(4'(i + 1)));
      @(negedge clk);
      chk($sformatf("drop_full_%0d", i), 32'(bus.job_full), 32'(i >= 4));
      chk($sformatf("drop_pulse_%0d", i), 32'(bus.job_drop), 32'(i == 5));
    end
    bus.job_push = 1'b0;
    @(negedge clk);
    chk("drop_clear", 32'(bus.job_drop), 0);
    drain();
    pop_en = 0;
    lat = 1;
    g0 = go_cnt;
    for (int i = 0; i < 6; i++) push_job(4'(i + 7));
    repeat (40) @(negedge clk);
    chk("nopop_res_empty", 32'(bus.res_empty), 0);
    chk("nopop_busy", 32'(bus.busy), 0);
    chk("nopop_go_writes", go_cnt - g0, 4);
    pop_one = 1;
    repeat (5) @(negedge clk);
    chk("nopop_fifth_started", go_cnt - g0, 5);
    pop_en = 1;
    drain();
    chk("nopop_all_go", go_cnt - g0, 6);
    never = 1;
    polls_q.delete();
    push_job(4'd3); push_job(4'd4);
    drain();
    chk("to_entries", polls_q.size(), 2);
    while (polls_q.size() > 0) chk("to_wait_cycles", polls_q.pop_front(), 8);
    never = 0;
    inject = 1; rand_lat = 1; rand_pop = 1;
    for (int i = 0; i < 40; i++) begin
      push_job(4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    push_job(4'd15);
    drain();
    inject = 0; rand_lat = 0; rand_pop = 0;
    never = 1;
    push_job(4'd1); push_job(4'd2); push_job(4'd3);
    t = 0;
    while (!(polling && cur_polls >= 3) && t < 100) begin @(negedge clk); t++; end
    chk("rst_mid_in_wait", 32'(polling && cur_polls >= 3), 1);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rmid_busy", 32'(bus.busy), 0);
    chk("rmid_acc_addr", 32'(bus.acc_addr), 2);
    chk("rmid_acc_we", 32'(bus.acc_we), 0);
    chk("rmid_res_empty", 32'(bus.res_empty), 1);
    chk("rmid_job_full", 32'(bus.job_full), 0);
    rst = 1'b0;
    never = 0;
    g0 = go_cnt;
    repeat (15) @(negedge clk);
    chk("rmid_idle_after", 32'(bus.busy), 0);
    chk("rmid_no_result", 32'(bus.res_empty), 1);
    chk("rmid_no_go", go_cnt - g0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
